// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// FSM states, ALU operation codes, opcode/funct constants.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ITYPE_EX = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [3:0] ALU_OR  = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  localparam int WAIT_W = 8;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) ||
           (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction fields, memory handshake and datapath
// control strobes between the controller and datapath.
interface multicycle_control_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemToReg;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [3:0] ALUOp;

  logic       illegal_instr;
  logic       bus_error;
  logic       halted;

  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead,
    output MemWrite, MemToReg, IRWrite, RegWrite,
    output RegDst, ALUSrcA, ALUSrcB, PCSource,
    output ALUOp, illegal_instr, bus_error, halted
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead,
    input  MemWrite, MemToReg, IRWrite, RegWrite,
    input  RegDst, ALUSrcA, ALUSrcB, PCSource,
    input  ALUOp, illegal_instr, bus_error, halted
  );

endinterface

// File: rtl/alu_op_decode.sv
// R-type funct to ALU operation mapping, shared with
// the single-cycle path; valid_o flags supported functs.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       valid_o
);

  always_comb begin
    alu_op_o = ALU_OR;
    valid_o  = 1'b1;
    unique case (1'b1)
      (funct_i == FN_ADD) || (funct_i == FN_ADDU):
        alu_op_o = ALU_ADD;
      (funct_i == FN_SUB) || (funct_i == FN_SUBU):
        alu_op_o = ALU_SUB;
      (funct_i == FN_AND):
        alu_op_o = ALU_AND;
      (funct_i == FN_OR):
        alu_op_o = ALU_OR;
      default:
        valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with memory wait
// timeout, sticky bus error and halt.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multicycle_control_if.master  bus
);

  state_e              state_q, state_d, st;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_err_q, bus_err_d;
  logic                rdst_q, rdst_d;
  logic                mem_st, rdy, timeout;
  logic                illegal;
  logic [3:0]          r_op;
  logic                r_ok;
  ctrl_t               c;

  alu_op_decode u_alu_op_decode (
    .funct_i  (bus.funct),
    .alu_op_o (r_op),
    .valid_o  (r_ok)
  );

  // Reset forces the FETCH view with mem_ready masked
  assign st      = reset_n ? state_q : S_FETCH;
  assign mem_st  = is_mem_state(st);
  assign rdy     = reset_n & bus.mem_ready & mem_st;
  assign timeout = mem_st & ~rdy &
                   (wait_q == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    state_d   = st;
    bus_err_d = bus_err_q;
    rdst_d    = rdst_q;
    illegal   = 1'b0;
    c         = '0;
    unique case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCS_ALU;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        if (rdy) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BOFF;
        c.alu_op    = ALU_ADD;
        unique case (1'b1)
          (bus.opcode == OP_LW) ||
          (bus.opcode == OP_SW):
            state_d = S_MEMADDR;
          (bus.opcode == OP_RTYPE) && r_ok:
            state_d = S_RTYPE_EX;
          (bus.opcode == OP_ADDI):
            state_d = S_ITYPE_EX;
          (bus.opcode == OP_BEQ):
            state_d = S_BRANCH;
          (bus.opcode == OP_J):
            state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        state_d     = (bus.opcode == OP_SW) ?
                      S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
        if (rdy) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
        if (rdy) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = r_op;
        rdst_d      = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ITYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        rdst_d      = 1'b0;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = rdst_q;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_OUT;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JMP;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Count restarts on every entry to a memory state
  always_comb begin
    wait_d = '0;
    if (mem_st && (state_d == st)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      rdst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      rdst_q    <= rdst_d;
    end
  end

  assign bus.PCWrite       = c.pc_write;
  assign bus.PCWriteCond   = c.pc_write_cond;
  assign bus.IorD          = c.ior_d;
  assign bus.MemRead       = c.mem_read;
  assign bus.MemWrite      = c.mem_write;
  assign bus.MemToReg      = c.mem_to_reg;
  assign bus.IRWrite       = c.ir_write;
  assign bus.RegWrite      = c.reg_write;
  assign bus.RegDst        = c.reg_dst;
  assign bus.ALUSrcA       = c.alu_src_a;
  assign bus.ALUSrcB       = c.alu_src_b;
  assign bus.PCSource      = c.pc_source;
  assign bus.ALUOp         = c.alu_op;
  assign bus.illegal_instr = illegal;
  assign bus.bus_error     = bus_err_q & reset_n;
  assign bus.halted        = (st == S_HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with MAX_WAIT=4;
// outputs packed into one vector and sampled mid-cycle.
module tb_multicycle_control;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  multicycle_control_if bus ();

  multicycle_control #(.MAX_WAIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {bus.PCWrite, bus.PCWriteCond,
                bus.IorD, bus.MemRead,
                bus.MemWrite, bus.MemToReg,
                bus.IRWrite, bus.RegWrite,
                bus.RegDst, bus.ALUSrcA,
                bus.ALUSrcB, bus.PCSource, bus.ALUOp,
                bus.illegal_instr, bus.bus_error,
                bus.halted};

  localparam logic [20:0] F0   = 21'b0001000000_01_00_0001_000;
  localparam logic [20:0] F1   = 21'b1001001000_01_00_0001_000;
  localparam logic [20:0] DEC  = 21'b0000000000_11_00_0001_000;
  localparam logic [20:0] DILL = 21'b0000000000_11_00_0001_100;
  localparam logic [20:0] MADR = 21'b0000000001_10_00_0001_000;
  localparam logic [20:0] MRD  = 21'b0011000000_00_00_0000_000;
  localparam logic [20:0] MWB  = 21'b0000010100_00_00_0000_000;
  localparam logic [20:0] MWR  = 21'b0010100000_00_00_0000_000;
  localparam logic [20:0] WBR  = 21'b0000000110_00_00_0000_000;
  localparam logic [20:0] WBI  = 21'b0000000100_00_00_0000_000;
  localparam logic [20:0] ITY  = 21'b0000000001_10_00_0001_000;
  localparam logic [20:0] BRA  = 21'b0100000001_00_01_0010_000;
  localparam logic [20:0] JMP  = 21'b1000000000_00_10_0000_000;
  localparam logic [20:0] HLT  = 21'b0000000000_00_00_0000_011;

  task automatic step(input logic rdy);
    @(negedge clk);
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      checks++;
      if (obs !== F0) begin
        errors++;
        $display("FAIL reset[%0d] got %b want %b", i, obs, F0);
      end
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.mem_ready = 1'b0;
    step(1'b0);
    checks++;
    if (obs !== F0) begin
      errors++;
      $display("FAIL reset_rel got %b want %b", obs, F0);
    end
  endtask

  task automatic test_lw();
    logic [20:0] ex [6] = '{F1, DEC, MADR, MRD, MWB, F0};
    logic rd [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b100011;
    bus.funct  = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL lw[%0d] got %b want %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [20:0] ex [5] = '{F1, DEC, MADR, MWR, F0};
    logic rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL sw[%0d] got %b want %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [6] = '{6'b100000, 6'b100001, 6'b100010,
                           6'b100011, 6'b100100, 6'b100101};
    logic [3:0] op [6] = '{4'b0001, 4'b0001, 4'b0010,
                           4'b0010, 4'b0011, 4'b0000};
    logic [20:0] ex [4];
    logic rd [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bus.opcode = 6'b000000;
    for (int f = 0; f < 6; f++) begin
      bus.funct = fn[f];
      ex[0] = F1;
      ex[1] = DEC;
      ex[2] = {10'b0000000001, 4'b0000, op[f], 3'b000};
      ex[3] = WBR;
      for (int i = 0; i < 4; i++) begin
        step(rd[i]);
        checks++;
        if (obs !== ex[i]) begin
          errors++;
          $display("FAIL rtype[%b][%0d] got %b want %b",
                   fn[f], i, obs, ex[i]);
        end
      end
    end
    step(1'b0);
    checks++;
    if (obs !== F0) begin
      errors++;
      $display("FAIL rtype_end got %b want %b", obs, F0);
    end
  endtask

  task automatic test_addi();
    logic [20:0] ex [5] = '{F1, DEC, ITY, WBI, F0};
    logic rd [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL addi[%0d] got %b want %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [20:0] eb [4] = '{F1, DEC, BRA, F0};
    logic [20:0] ej [4] = '{F1, DEC, JMP, F0};
    logic rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== eb[i]) begin
        errors++;
        $display("FAIL beq[%0d] got %b want %b", i, obs, eb[i]);
      end
    end
    bus.opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== ej[i]) begin
        errors++;
        $display("FAIL j[%0d] got %b want %b", i, obs, ej[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [20:0] ex [3] = '{F1, DILL, F0};
    logic rd [3] = '{1'b1, 1'b0, 1'b0};
    logic [5:0] opc [2] = '{6'b111111, 6'b000000};
    bus.funct = 6'b101010;
    for (int k = 0; k < 2; k++) begin
      bus.opcode = opc[k];
      for (int i = 0; i < 3; i++) begin
        step(rd[i]);
        checks++;
        if (obs !== ex[i]) begin
          errors++;
          $display("FAIL illegal[%b][%0d] got %b want %b",
                   opc[k], i, obs, ex[i]);
        end
      end
    end
  endtask

  task automatic test_fetch_wait();
    logic [20:0] ex [7] = '{F0, F0, F0, F1, DEC, JMP, F0};
    logic rd [7] = '{1'b0, 1'b0, 1'b0, 1'b1,
                     1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b000010;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL fetch_wait[%0d] got %b want %b",
                 i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_read_boundary();
    logic [20:0] ex [9] = '{F1, DEC, MADR, MRD, MRD,
                            MRD, MRD, MWB, F0};
    logic rd [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b0, 1'b1, 1'b0, 1'b0};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL rd_bound[%0d] got %b want %b",
                 i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [20:0] ex [10] = '{F1, DEC, MADR, MWR, MWR,
                             MWR, MWR, HLT, HLT, HLT};
    logic rd [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.opcode = 6'b101011;
    for (int i = 0; i < 10; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL timeout[%0d] got %b want %b",
                 i, obs, ex[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== F0) begin
      errors++;
      $display("FAIL halt_in_rst got %b want %b", obs, F0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.mem_ready = 1'b0;
    step(1'b0);
    checks++;
    if (obs !== F0) begin
      errors++;
      $display("FAIL halt_cleared got %b want %b", obs, F0);
    end
  endtask

  task automatic test_reset_midaccess();
    logic [20:0] ex [4] = '{F1, DEC, MADR, MRD};
    logic rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      step(rd[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL mid_rst[%0d] got %b want %b",
                 i, obs, ex[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== F0) begin
      errors++;
      $display("FAIL mid_rst_hold got %b want %b", obs, F0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.mem_ready = 1'b0;
    step(1'b0);
    checks++;
    if (obs !== F0) begin
      errors++;
      $display("FAIL mid_rst_after got %b want %b", obs, F0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'b000000;
    bus.funct = 6'b000000;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_addi();
    test_branch_jump();
    test_illegal();
    test_fetch_wait();
    test_read_boundary();
    test_timeout();
    test_reset_midaccess();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MAX_WAIT, default 255: maximum cycles to wait for mem_ready in any memory state (1..255).
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 opcode  input  6  instruction[31:26], taken from the instruction register.
REQ-005 funct  input  6  instruction[5:0], taken from the instruction register.
REQ-006 mem_ready  input  1  memory completes the current MemRead/MemWrite access this cycle.
REQ-007 Datapath-control outputs SHALL be PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA (each 1 bit), ALUSrcB (2), PCSource (2) and ALUOp (4).
REQ-008 illegal_instr  output  1  one-cycle pulse in DECODE when opcode/funct is unsupported.
REQ-009 bus_error  output  1  sticky flag set on memory timeout.
REQ-010 halted  output  1  high while the FSM is in HALT.

Function
REQ-011 The FSM SHALL have states FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, RTYPE_EX, ITYPE_EX, ALUWB, BRANCH, JUMP and HALT, held in a registered state vector.
REQ-012 Outputs SHALL be combinational from the state, plus mem_ready in memory states; any output not listed for a state SHALL be 0.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00; IRWrite=PCWrite=mem_ready; stay until mem_ready, then go to DECODE.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target). Next state by opcode: 100011/101011 to MEMADDR; 000000 with funct in {100000,100001,100010,100011,100100,100101} to RTYPE_EX; 001000 to ITYPE_EX; 000100 to BRANCH; 000010 to JUMP; all other codes pulse illegal_instr and go to FETCH.
REQ-015 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD; go to MEMREAD for lw, MEMWRITE for sw.
REQ-016 MEMREAD: MemRead=1, IorD=1; wait for mem_ready, then go to MEMWB. MEMWB: RegWrite=1, MemToReg=1, RegDst=0; then go to FETCH.
REQ-017 MEMWRITE: MemWrite=1, IorD=1; wait for mem_ready, then go to FETCH.
REQ-018 RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp from funct: add/addu=0001, sub/subu=0010, and=0011, or=0000.
REQ-019 ITYPE_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=0001. Both RTYPE_EX and ITYPE_EX go to ALUWB.
REQ-020 ALUWB: RegWrite=1, MemToReg=0, RegDst=1 when entered from RTYPE_EX and 0 when entered from ITYPE_EX; a 1-bit register records which; then go to FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0010, PCWriteCond=1, PCSource=01; then go to FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; then go to FETCH.
REQ-023 Zero-wait latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-024 Each memory state SHALL run a wait counter that clears on entry and increments every cycle mem_ready is low.
REQ-025 If the wait count reaches MAX_WAIT with mem_ready still low, the FSM SHALL set bus_error and go to HALT.
REQ-026 mem_ready arriving in the same cycle the count reaches MAX_WAIT SHALL complete the access normally, with no error.
REQ-027 HALT SHALL drive all control outputs to 0 and hold halted=1 until reset.
REQ-028 mem_ready SHALL be ignored in every non-memory state.

Reset
REQ-029 When reset_n=0 at a rising clk edge, state SHALL become FETCH and wait counter, bus_error and the RegDst select register SHALL clear, even mid-access.
REQ-030 While in reset, all outputs SHALL equal their FETCH values with mem_ready treated as 0 (MemRead=1, write strobes 0).

Structure
REQ-031 State encodings, ALUOp codes (OR=0000, ADD=0001, SUB=0010, AND=0011), and the opcode and funct constants SHALL reside in a shared package mips_ctrl_pkg.
REQ-032 The funct-to-ALUOp mapping SHALL be one sub-module, alu_op_decode, reusable by the single-cycle path.

Verification
REQ-033 lw (opcode 100011) with mem_ready=1 each memory cycle: states FETCH, DECODE, MEMADDR, MEMREAD, MEMWB; RegWrite=MemToReg=1 in cycle 5.
REQ-034 sub (funct 100010): ALUOp=0010 in RTYPE_EX, then RegWrite=1 and RegDst=1 in ALUWB; addi (001000): RegDst=0 in ALUWB.
REQ-035 FETCH with mem_ready low for 3 cycles: IRWrite and PCWrite stay 0 until cycle 4, then each is 1 for exactly one cycle.
REQ-036 MAX_WAIT=4 with mem_ready stuck low in MEMWRITE: bus_error=1 and halted=1 after 4 cycles; remains until reset_n=0.
REQ-037 opcode 111111: illegal_instr=1 for one cycle in DECODE, then FETCH; no RegWrite or MemWrite asserted.
REQ-038 reset_n=0 during MEMREAD: FETCH on the next cycle with MemWrite=0 and RegWrite=0.
